// File: rtl/instruction_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit ISA words and
// writes them to instruction memory at consecutive addresses from a base.
// Ports: clk, rst_n (async active-low), start/base/len job control,
// in_valid/in_ready field handshake, funtype/funcode/rd/rs/rx/selimm/imm
// fields, mem_we/mem_addr/mem_wdata/mem_ack memory write port,
// busy/done/err status.
// Optional macro INSTR_ENC_CHECK_EN: field legality checking and err flag.
module instruction_encoder #(
    parameter int AW = 10,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    funtype,
    input  logic [1:0]    funcode,
    input  logic [3:0]    rd,
    input  logic [3:0]    rs,
    input  logic [3:0]    rx,
    input  logic          selimm,
    input  logic [31:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic [31:0]   enc;
    logic          is_reg, is_cwr;
    logic          illegal;
    logic          hs;

    assign is_reg = (funtype == 2'b00);
    assign is_cwr = (funtype == 2'b11) && (funcode == 2'b10);
    assign hs     = in_valid && (state_q == RUN);

    always_comb begin
        enc = '0;
        enc[31:28] = {funtype, funcode};
        if (is_reg) begin
            enc[27:24] = rd;
            enc[23:20] = rs;
            if (selimm) begin
                enc[19:1] = imm[18:0];
                enc[0]    = 1'b1;
            end else begin
                enc[19:16] = rx;
            end
        end else if (is_cwr) begin
            // cache write carries a 4-bit immediate in the rs slot
            enc[27:24] = rd;
            enc[23:20] = imm[3:0];
            enc[19:16] = rx;
        end else if (selimm) begin
            enc[27:0] = imm[27:0];
        end else begin
            enc[27:24] = rd;
            enc[23:20] = rs;
            enc[19:16] = rx;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    always_comb begin
        illegal = 1'b0;
        if (is_reg) begin
            illegal = selimm && (imm[31:19] != '0);
        end else if (is_cwr) begin
            illegal = (imm[31:4] != '0);
        end else if (selimm) begin
            illegal = (imm[31:28] != '0) || !imm[0];
        end
    end
`else
    assign illegal = 1'b0;
`endif

    logic unused_imm;
    assign unused_imm = ^imm[31:28];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base;
                    remain_d = len;
                    err_d    = 1'b0;
                    state_d  = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (illegal) begin
                        // dropped word still consumes a slot of the job
                        err_d    = 1'b1;
                        remain_d = remain_q - 1'b1;
                        if (remain_q == LW'(1)) state_d = FIN;
                    end else begin
                        wdata_d = enc;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    state_d  = (remain_q == LW'(1)) ? FIN : RUN;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // status decoded straight from state so reset drops them at once
    assign in_ready  = (state_q == RUN);
    assign mem_we    = (state_q == WAIT);
    assign busy      = (state_q == RUN) || (state_q == WAIT);
    assign done      = (state_q == FIN);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: directed and random jobs checked
// against an arithmetic reference model of the instruction encoding.
module tb_instruction_encoder;

    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    funtype;
    logic [1:0]    funcode;
    logic [3:0]    rd, rs, rx;
    logic          selimm;
    logic [31:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic          busy, done, err;

    instruction_encoder #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .funtype(funtype), .funcode(funcode),
        .rd(rd), .rs(rs), .rx(rx), .selimm(selimm), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int exp_addr = 0;
    int remain = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(
        input int ft, input int fc, input int d, input int s,
        input int x, input bit sel, input longint unsigned iv);
        longint unsigned w;
        w = longint'(ft) * 64'h4000_0000 + longint'(fc) * 64'h1000_0000;
        if (ft == 0) begin
            w += longint'(d) * 64'h100_0000 + longint'(s) * 64'h10_0000;
            if (sel) w += (iv % 64'h8_0000) * 2 + 1;
            else     w += longint'(x) * 64'h1_0000;
        end else if (ft == 3 && fc == 2) begin
            w += longint'(d) * 64'h100_0000 + (iv % 16) * 64'h10_0000
               + longint'(x) * 64'h1_0000;
        end else if (sel) begin
            w += iv % 64'h1000_0000;
        end else begin
            w += longint'(d) * 64'h100_0000 + longint'(s) * 64'h10_0000
               + longint'(x) * 64'h1_0000;
        end
        return w[31:0];
    endfunction

    function automatic bit ref_legal(input int ft, input int fc,
                                     input bit sel, input longint unsigned iv);
`ifdef INSTR_ENC_CHECK_EN
        if (ft == 0) return !sel || iv < 64'h8_0000;
        if (ft == 3 && fc == 2) return iv < 16;
        if (sel) return iv < 64'h1000_0000 && (iv % 2) == 1;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        start = 1'b1;
        base  = AW'(b);
        len   = LW'(l);
        tick();
        start = 1'b0;
        exp_addr = b;
        remain   = l;
        exp_err  = 1'b0;
        chk("start_err_clr", {31'b0, err}, 0);
        if (l == 0) begin
            chk("len0_done", {31'b0, done}, 1);
            chk("len0_we", {31'b0, mem_we}, 0);
            tick();
            chk("len0_done_low", {31'b0, done}, 0);
        end else begin
            chk("start_busy", {31'b0, busy}, 1);
        end
    endtask

    task automatic drive(input int ft, input int fc, input int d,
                         input int s, input int x, input bit sel,
                         input logic [31:0] iv);
        funtype = 2'(ft);
        funcode = 2'(fc);
        rd = 4'(d);
        rs = 4'(s);
        rx = 4'(x);
        selimm = sel;
        imm = iv;
    endtask

    task automatic send(input int ft, input int fc, input int d,
                        input int s, input int x, input bit sel,
                        input logic [31:0] iv, input int ackdly);
        logic [31:0] w;
        w = ref_word(ft, fc, d, s, x, sel, longint'(iv));
        chk("in_ready_run", {31'b0, in_ready}, 1);
        drive(ft, fc, d, s, x, sel, iv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        remain--;
        if (ref_legal(ft, fc, sel, longint'(iv))) begin
            chk("we", {31'b0, mem_we}, 1);
            chk("addr", 32'(mem_addr), 32'(exp_addr));
            chk("wdata", mem_wdata, w);
            chk("ready_wait", {31'b0, in_ready}, 0);
            for (int i = 0; i < ackdly; i++) begin
                tick();
                chk("we_hold", {31'b0, mem_we}, 1);
                chk("addr_hold", 32'(mem_addr), 32'(exp_addr));
                chk("wdata_hold", mem_wdata, w);
                chk("ready_hold", {31'b0, in_ready}, 0);
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            exp_addr = (exp_addr + 1) % (1 << AW);
        end else begin
            exp_err = 1'b1;
            chk("drop_we", {31'b0, mem_we}, 0);
        end
        chk("err", {31'b0, err}, {31'b0, exp_err});
        if (remain == 0) begin
            chk("done", {31'b0, done}, 1);
            chk("busy_fin", {31'b0, busy}, 0);
            tick();
            chk("done_pulse", {31'b0, done}, 0);
        end else begin
            chk("not_done", {31'b0, done}, 0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        base = '0;
        len = '0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        rst_n = 1'b1;
        tick();

        // reg ADD
        do_start(32'h010, 1);
        send(0, 0, 3, 4, 5, 1'b0, 32'h0, 0);
        chk("add_word", ref_word(0, 0, 3, 4, 5, 1'b0, 0), 32'h03450000);

        // reg immediate, then an out-of-range one
        do_start(32'h020, 2);
        send(0, 1, 1, 2, 0, 1'b1, 32'h7FFFF, 0);
        send(0, 1, 1, 2, 0, 1'b1, 32'h80000, 0);

        // kernel cache write and mem immediate
        do_start(32'h030, 2);
        send(3, 2, 6, 0, 0, 1'b0, 32'hA, 1);
        send(1, 0, 0, 0, 0, 1'b1, 32'h0ABCDEF1, 0);

        // slow memory
        do_start(32'h040, 3);
        for (int i = 0; i < 3; i++) send(2, i, i, i + 1, i + 2, 1'b0, 32'h0, 4);

        // address wrap with a stray start mid-job
        do_start(32'h3FF, 2);
        send(1, 1, 7, 8, 9, 1'b0, 32'h0, 0);
        start = 1'b1;
        base = AW'(32'h100);
        len = LW'(5);
        tick();
        start = 1'b0;
        chk("stray_start_ready", {31'b0, in_ready}, 1);
        send(1, 2, 9, 8, 7, 1'b0, 32'h0, 0);
        chk("after_wrap_idle", {31'b0, busy}, 0);

        // random jobs
        for (int j = 0; j < 4; j++) begin
            n = $urandom_range(1, 6);
            do_start($urandom_range(0, (1 << AW) - 1), n);
            for (int k = 0; k < n; k++) begin
                send($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? $urandom()
                                                 : $urandom_range(0, 15),
                     $urandom_range(0, 2));
            end
        end

        // reset while a word waits for ack
        do_start(32'h050, 2);
        drive(0, 0, 1, 1, 1, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_we", {31'b0, mem_we}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {31'b0, mem_we}, 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_ready", {31'b0, in_ready}, 0);
        chk("arst_done", {31'b0, done}, 0);
        chk("arst_err", {31'b0, err}, 0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("post_rst_we", {31'b0, mem_we}, 0);
        chk("post_rst_busy", {31'b0, busy}, 0);
        do_start(32'h060, 0);
        chk("len0_idle", {31'b0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
